// File: rtl/serial_word_rx_pkg.sv
// serial_word_rx_pkg: framing constants and FSM state encoding shared by the
// serial receiver and the serializer-side framing logic.
package serial_word_rx_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if: valid/ready word port between the receiver and its consumer.
//   Q      received word, stable while valid=1 (driven by master)
//   valid  Q holds an unread word (driven by master)
//   ready  consumer accepts Q when valid & ready (driven by slave)
interface serial_word_rx_if #(
    parameter int N = 8
);
    logic [N-1:0] Q;
    logic         valid;
    logic         ready;

    modport master (output Q, output valid, input ready);
    modport slave  (input Q, input valid, output ready);
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx: framed serial-to-parallel receiver (start, N data bits MSB
// first, optional even parity, stop) presenting words on a valid/ready port.
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   Sin        serial line, idles 0
//   rx         word port (Q/valid out, ready in)
//   busy       frame in progress
//   parity_err one-cycle pulse, parity mismatch, word discarded
//   frame_err  one-cycle pulse, stop bit was 1, word discarded
//   overrun    sticky: good word dropped while valid & !ready; cleared by handshake
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int N         = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     Sin,
    serial_word_rx_if.master         rx,
    output logic                     busy,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overrun
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    rx_state_t     st, st_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sr;
    logic [N-1:0]  q_r;
    logic          p;
    logic          valid_r;
    logic          stop_bad, par_bad, good, take, accept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= ST_IDLE;
        else       st <= st_nx;
    end

    // The stop sample always returns to IDLE, so a 1 seen at STOP can never
    // be taken as the next start bit.
    always_comb begin
        st_nx = st;
        case (st)
            ST_IDLE:   st_nx = (Sin == START_BIT) ? ST_DATA : ST_IDLE;
            ST_DATA:   st_nx = (cnt == LAST) ? (PARITY_EN ? ST_PARITY : ST_STOP) : ST_DATA;
            ST_PARITY: st_nx = ST_STOP;
            ST_STOP:   st_nx = ST_IDLE;
            default:   st_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (st != ST_IDLE);
    end

    // Stop-bit error outranks parity; both are only meaningful on the STOP sample.
    assign stop_bad = (st == ST_STOP) && (Sin != STOP_BIT);
    assign par_bad  = (st == ST_STOP) && PARITY_EN && (^{sr, p});
    assign good     = (st == ST_STOP) && !stop_bad && !par_bad;
    assign take     = valid_r && rx.ready;
    assign accept   = good && (!valid_r || rx.ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            sr         <= '0;
            p          <= 1'b0;
            q_r        <= '0;
            valid_r    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cnt        <= (st == ST_DATA && cnt != LAST) ? cnt + 1'b1 : '0;
            sr         <= (st == ST_DATA) ? {sr[N-2:0], Sin} : sr;
            p          <= (st == ST_PARITY) ? Sin : p;
            q_r        <= accept ? sr : q_r;
            valid_r    <= accept ? 1'b1 : (take ? 1'b0 : valid_r);
            frame_err  <= stop_bad;
            parity_err <= par_bad && !stop_bad;
            overrun    <= take ? 1'b0 : ((good && valid_r && !rx.ready) ? 1'b1 : overrun);
        end
    end

    assign rx.Q     = q_r;
    assign rx.valid = valid_r;
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed bench for serial_word_rx, one N=8 parity
// instance (dut_a) and one N=4 no-parity instance (dut_b).
module tb_serial_word_rx;
    import serial_word_rx_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic sin_a, sin_b;
    logic busy_a, perr_a, ferr_a, ovr_a;
    logic busy_b, perr_b, ferr_b, ovr_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_word_rx_if #(.N(8)) bus_a ();
    serial_word_rx_if #(.N(4)) bus_b ();

    serial_word_rx #(.N(8), .PARITY_EN(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .Sin(sin_a), .rx(bus_a.master),
        .busy(busy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
    );

    serial_word_rx #(.N(4), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .Sin(sin_b), .rx(bus_b.master),
        .busy(busy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit on the chosen line and let it be sampled by the next rising edge.
    task automatic tx(input int which, input logic b);
        if (which == 0) sin_a = b;
        else            sin_b = b;
        @(negedge clk);
    endtask

    task automatic frame_a(input logic [7:0] d, input logic p, input logic stop);
        tx(0, START_BIT);
        for (int i = 7; i >= 0; i--) tx(0, d[i]);
        tx(0, p);
        tx(0, stop);
    endtask

    initial begin
        logic [3:0] nib;
        rstn = 1'b0;
        sin_a = IDLE_LEVEL;
        sin_b = IDLE_LEVEL;
        bus_a.ready = 1'b1;
        bus_b.ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus_a.valid, 0);
        chk("rst_q", bus_a.Q, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_errs", {perr_a, ferr_a, ovr_a}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: good frame A5, even parity 0
        frame_a(8'hA5, 1'b0, STOP_BIT);
        chk("t1_valid", bus_a.valid, 1);
        chk("t1_q", bus_a.Q, 32'hA5);
        chk("t1_errs", {perr_a, ferr_a, ovr_a}, 0);
        chk("t1_busy", busy_a, 0);
        tx(0, IDLE_LEVEL);
        chk("t1_valid_drop", bus_a.valid, 0);

        // 2: 3C with wrong parity bit
        frame_a(8'h3C, 1'b1, STOP_BIT);
        chk("t2_perr", perr_a, 1);
        chk("t2_ferr", ferr_a, 0);
        chk("t2_valid", bus_a.valid, 0);
        chk("t2_q", bus_a.Q, 32'hA5);
        tx(0, IDLE_LEVEL);
        chk("t2_perr_pulse", perr_a, 0);

        // 3: FF with stop bit 1
        frame_a(8'hFF, 1'b0, 1'b1);
        chk("t3_ferr", ferr_a, 1);
        chk("t3_perr", perr_a, 0);
        chk("t3_busy", busy_a, 0);
        chk("t3_valid", bus_a.valid, 0);
        tx(0, IDLE_LEVEL);
        chk("t3_ferr_pulse", ferr_a, 0);
        chk("t3_no_restart", busy_a, 0);

        // 4: overrun with back-to-back frames while consumer stalls
        bus_a.ready = 1'b0;
        frame_a(8'h12, 1'b0, STOP_BIT);
        chk("t4_valid1", bus_a.valid, 1);
        chk("t4_q1", bus_a.Q, 32'h12);
        chk("t4_ovr1", ovr_a, 0);
        frame_a(8'h34, 1'b1, STOP_BIT);
        chk("t4_q_held", bus_a.Q, 32'h12);
        chk("t4_valid2", bus_a.valid, 1);
        chk("t4_ovr2", ovr_a, 1);
        bus_a.ready = 1'b1;
        tx(0, IDLE_LEVEL);
        chk("t4_valid_clr", bus_a.valid, 0);
        chk("t4_ovr_clr", ovr_a, 0);

        // 5: asynchronous reset partway through C3
        tx(0, START_BIT);
        tx(0, 1'b1); tx(0, 1'b1); tx(0, 1'b0); tx(0, 1'b0);
        chk("t5_busy_pre", busy_a, 1);
        rstn = 1'b0;
        #1;
        chk("t5_busy", busy_a, 0);
        chk("t5_q", bus_a.Q, 0);
        chk("t5_outs", {bus_a.valid, perr_a, ferr_a, ovr_a}, 0);
        sin_a = IDLE_LEVEL;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        frame_a(8'h5A, 1'b0, STOP_BIT);
        chk("t5_valid", bus_a.valid, 1);
        chk("t5_q_after", bus_a.Q, 32'h5A);
        chk("t5_errs", {perr_a, ferr_a}, 0);
        tx(0, IDLE_LEVEL);

        // 6: N=4 without parity, 20 gapless frames
        for (int k = 0; k < 20; k++) begin
            nib = 4'($urandom_range(0, 15));
            tx(1, START_BIT);
            chk("t6_valid_gap", bus_b.valid, 0);
            for (int i = 3; i >= 0; i--) tx(1, nib[i]);
            tx(1, STOP_BIT);
            chk("t6_valid", bus_b.valid, 1);
            chk("t6_q", bus_b.Q, 32'(nib));
            chk("t6_errs", {perr_b, ferr_b, ovr_b}, 0);
        end
        tx(1, IDLE_LEVEL);
        chk("t6_valid_end", bus_b.valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
